// File: rtl/mac_array_ctrl.sv
// Purpose : job sequencer for a MAC array: clear, stream k_len compute beats, drain one result per lane.
// Latency : start -> load_en 1 cycle; compute beats follow in_valid; drain ARRAY_SIZE transfers; done pulse after the last one.
// Backpres: in_valid stalls hold the beat count; out_ready=0 holds out_idx/out_data until the transfer completes.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, k_len        job request (sampled in IDLE) and its compute-beat count
//   busy, done          not-IDLE flag, one-cycle end-of-job pulse
//   in_valid, in_ready  operand-stream handshake (ready only in COMPUTE)
//   load_en, compute    array strobes: accumulator clear, MAC enable
//   acc                 per-lane accumulator values from the array
//   out_valid/out_ready/out_data/out_idx  result drain stream, lane 0 first
//   stall_cycles        only with MAC_ARRAY_CTRL_PERF_EN defined: saturating stall counter
module mac_array_ctrl #(
  parameter int ARRAY_SIZE             = 2,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int K_WIDTH                = 8,
  localparam int IDX_W                 = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [K_WIDTH-1:0]                                 k_len,
  output logic                                               busy,
  output logic                                               done,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  output logic                                               load_en,
  output logic                                               compute,
  input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]  acc,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [ACCUMULATOR_DATA_WIDTH-1:0]                  out_data,
  output logic [IDX_W-1:0]                                   out_idx
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]                                        stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  state_t             state, state_n;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [K_WIDTH-1:0] k_lat;
  logic               accept;
  logic               last_beat;
  logic               xfer;

  assign accept = (state == IDLE) && start;
  // Compare against k_lat-1 so k_lat = all-ones finishes without the counter wrapping.
  assign last_beat = (beat_cnt == (k_lat - K_WIDTH'(1)));
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      k_lat    <= '0;
      out_idx  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        k_lat    <= k_len;
        beat_cnt <= '0;
        out_idx  <= '0;
      end else begin
        if (in_valid && in_ready) beat_cnt <= beat_cnt + K_WIDTH'(1);
        if (xfer) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_n   = state;
    load_en   = 1'b0;
    compute   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (k_len == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        load_en = 1'b1;
        state_n = COMPUTE;
      end
      COMPUTE: begin
        in_ready = 1'b1;
        compute  = in_valid;
        if (in_valid && last_beat) state_n = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (out_idx == LAST_IDX)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign out_data = acc[out_idx];

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic stall_evt;
  assign stall_evt = ((state == COMPUTE) && !in_valid) || ((state == DRAIN) && !out_ready);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles <= '0;
    end else if (stall_evt && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 The module SHALL have parameter ARRAY_SIZE, default 2, the number of MAC lanes sequenced.
REQ-002 The module SHALL have parameter ACCUMULATOR_DATA_WIDTH, default 16, the accumulator width per lane.
REQ-003 The module SHALL have parameter K_WIDTH, default 8, the width of the compute-beat count.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-007 The module SHALL have port k_len, input, K_WIDTH: compute beats for the job, latched on start acceptance.
REQ-008 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: a one-cycle pulse at job end.
REQ-010 The module SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand-stream handshake.
REQ-011 The module SHALL have ports load_en and compute, outputs, 1 bit each: the array control strobes.
REQ-012 The module SHALL have port acc, input, ARRAY_SIZE x ACCUMULATOR_DATA_WIDTH: the array accumulator values.
REQ-013 The module SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, ACCUMULATOR_DATA_WIDTH) and out_idx (output, $clog2(ARRAY_SIZE) bits, minimum 1): the result drain stream.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, CLEAR, COMPUTE, DRAIN and DONE.
REQ-015 In IDLE, start=1 with k_len!=0 SHALL latch k_len and go to CLEAR on the next cycle.
REQ-016 In IDLE, start=1 with k_len==0 SHALL go directly to DONE with no load_en, compute or out_valid.
REQ-017 CLEAR SHALL last exactly one cycle with load_en=1, then go to COMPUTE.
REQ-018 In COMPUTE, in_ready SHALL be 1 and compute SHALL equal in_valid.
REQ-019 The beat counter SHALL increment only on in_valid&&in_ready.
REQ-020 On the accepted beat that makes the count equal the latched k_len, the FSM SHALL go to DRAIN next cycle; stall cycles (in_valid=0) SHALL not count.
REQ-021 In DRAIN, out_valid SHALL be 1, out_data SHALL equal acc[out_idx], and out_idx SHALL start at 0.
REQ-022 In DRAIN, out_idx SHALL advance only on out_valid&&out_ready, and out_data/out_idx SHALL hold stable while out_ready=0.
REQ-023 The transfer at out_idx==ARRAY_SIZE-1 SHALL go to DONE next cycle.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; start in DONE SHALL be ignored.
REQ-025 Outside its named state, each of load_en, compute, in_ready, out_valid and done SHALL be 0.
REQ-026 start while busy=1 SHALL be ignored, and k_len changes while busy SHALL not affect the running job.
REQ-027 The beat counter SHALL be K_WIDTH bits; k_len = 2^K_WIDTH-1 SHALL complete without wrap.

Reset
REQ-028 When rst=1 at a clock edge, the FSM SHALL enter IDLE and the beat counter, out_idx and latched k_len SHALL clear to 0.
REQ-029 During and after reset, busy, done, load_en, compute, in_ready and out_valid SHALL be 0.
REQ-030 Reset asserted mid-job, in any state, SHALL abort the job with no done pulse.
REQ-031 start sampled in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-032 When MAC_ARRAY_CTRL_PERF_EN is defined, the module SHALL add a 32-bit output stall_cycles that counts COMPUTE cycles with in_valid=0 plus DRAIN cycles with out_ready=0.
REQ-033 stall_cycles SHALL clear on reset and on start acceptance, saturate at 2^32-1, and hold its value in IDLE.
REQ-034 When MAC_ARRAY_CTRL_PERF_EN is undefined, the stall_cycles port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 k_len=3, in_valid always 1, out_ready always 1, ARRAY_SIZE=2: start at cycle 0 -> load_en at cycle 1, compute at cycles 2-4, out_valid at cycles 5-6 (idx 0,1), done at cycle 7.
REQ-036 k_len=2, in_valid pattern 1,0,0,1 -> compute asserted in exactly 2 cycles, DRAIN entered after the 4th COMPUTE cycle.
REQ-037 out_ready held 0 for 3 cycles in DRAIN -> out_idx=0 and out_data=acc[0] stable throughout, then completes normally.
REQ-038 start with k_len=0 -> done one cycle later, load_en, compute and out_valid never asserted.
REQ-039 rst pulsed mid-COMPUTE -> next cycle busy=0, no done, and a fresh start with k_len=1 completes correctly.
REQ-040 With MAC_ARRAY_CTRL_PERF_EN defined, scenario REQ-036 plus 3 out_ready=0 cycles -> stall_cycles=5 at done.
